frame_offset_reader: RTL and testbench
======================================

Name: frame_offset_reader

Overview:
- Sits directly downstream of the VGA filter stage; consumes its signed shake offsets (oX_Offset/oY_Offset) plus VGA timing/coordinates.
- Converts each 640x480 display pixel, shifted by a per-frame-latched offset, into a read address for the 320x240 QVGA frame buffer (2x upscale).
- Returns the fetched RGB444 pixel, or the border colour for out-of-range coordinates.
- Delays sync/DE/X/Y by the same latency so the pixel stream leaves time-aligned for the filter's colour path.

Parameters:
- H_ACT, 640, active display width in pixels.
- V_ACT, 480, active display height in lines.
- SCALE_SHIFT, 1, log2 upscale factor; buffer is (H_ACT>>SCALE_SHIFT) x (V_ACT>>SCALE_SHIFT).
- RD_LATENCY, 1, frame-buffer read latency in cycles; legal range 1..3.
- BORDER_RGB, 12'h000, {R,G,B} driven for out-of-range pixels.

Ports:
- iClk  in  1  pixel clock (25 MHz).
- iRst_n  in  1  synchronous reset, active-low.
- iH_Sync  in  1  horizontal sync from timing generator.
- iV_Sync  in  1  vertical sync from timing generator.
- iDE  in  1  display-enable (active area).
- iX  in  10  current pixel column.
- iY  in  10  current pixel line.
- iX_Offset  in  5 signed  horizontal shake offset (-16..+15).
- iY_Offset  in  5 signed  vertical shake offset (-16..+15).
- oRd_Addr  out  17  frame-buffer read address (0..76799 at defaults).
- oRd_En  out  1  read strobe.
- iRd_Data  in  12  frame-buffer data {R,G,B}; valid RD_LATENCY cycles after oRd_En.
- oH_Sync, oV_Sync, oDE  out  1 each  delayed timing.
- oX, oY  out  10 each  delayed unshifted coordinates.
- oR, oG, oB  out  4 each  pixel colour.
- oFrame_Tick  out  1  one-cycle pulse when new offsets are latched.

Behaviour:
- Reset (iRst_n=0 sampled at iClk):
  - All outputs 0, latched offsets 0, all pipeline stages cleared.
  - Reset asserted mid-frame flushes the pipeline; no stale pixel appears after release.
- Frame boundary:
  - Registered iV_Sync rising edge (prev=0, cur=1).
  - On that cycle, iX_Offset/iY_Offset are captured into rXo/rYo and oFrame_Tick pulses for 1 cycle.
  - Offsets are constant for the whole following frame.
  - Offset inputs are ignored at every other time.
- Stage S1 (register inputs):
  - sx = iX + rXo and sy = iY + rYo, computed as 11-bit signed (sign-extend both operands).
  - in_range = iDE & 0<=sx<H_ACT & 0<=sy<V_ACT.
- Stage S2:
  - oRd_Addr = (sy>>SCALE_SHIFT)*(H_ACT>>SCALE_SHIFT) + (sx>>SCALE_SHIFT). At defaults this is implemented as shifts: (y<<8)+(y<<6)+x.
  - oRd_En = in_range. oRd_Addr holds its previous value when oRd_En=0.
- Output stage, registered RD_LATENCY cycles after S2:
  - DE=1 & in_range: {oR,oG,oB} = iRd_Data.
  - DE=1 & !in_range: {oR,oG,oB} = BORDER_RGB.
  - DE=0: {oR,oG,oB} = 0.
- Total latency iX/iDE -> oR/oDE = 2 + RD_LATENCY cycles (3 at default). H_Sync, V_Sync, DE, X, Y and in_range all go through the same-depth shift register.
- Boundaries:
  - Offset 0: oRd_Addr for (639,479) = 76799.
  - Offset -16 at x=5: sx = -11, treated as out of range.
  - Offset +15 at x=630: sx = 645, treated as out of range.
- No backpressure: the frame buffer must accept one read per cycle.

Optional Feature:
- Macro FRAME_READER_WRAP_EN.
  - Defined: out-of-range sx/sy wrap modulo H_ACT/V_ACT (sx<0 -> sx+H_ACT; sx>=H_ACT -> sx-H_ACT; same for y). oRd_En = iDE. BORDER_RGB is never used while DE=1.
  - Undefined: border behaviour as above.
- Latency is identical in both builds.

Decomposition:
- Shared package (e.g. vga_pkg): H_ACT/V_ACT defaults, rgb444 typedef (struct R,G,B 4-bit), coord typedef (10-bit), signed offset typedef (5-bit), frame-buffer address width constant (17).
- One sub-module: delay_line (parameterised width/depth shift register with synchronous active-low reset). Used for the timing/coordinate/in_range alignment path.

Test Plan:
- Reset: hold iRst_n=0 for 4 cycles with random inputs -> all outputs 0. After release, the first valid pixel emerges exactly 3 cycles after its iDE.
- Zero offset, full frame with RAM model returning data=addr[11:0] -> pixel (0,0) addr 0; (1,0) addr 0; (2,0) addr 1; (639,479) addr 76799; oR/oG/oB match the model; oDE aligned 3 cycles.
- Offset latch: hold iX_Offset=+3 mid-frame, then change to -4 without a V_Sync edge -> addresses unaffected. After the V_Sync rising edge: oFrame_Tick=1 for 1 cycle, and (10,0) reads addr 3 ((10-4)>>1).
- Border: latched offsets X=-16, Y=+15 -> x<16 and y>=465 give oRd_En=0 and RGB=BORDER_RGB; x=16,y=0 reads addr 7*320+0=2240.
- WRAP_EN build: X offset -16 at x=0 -> sx=624, addr 312, oRd_En=1.
- Reset mid-frame at line 200: outputs 0 the next cycle. Pipeline empty after release; no leftover oRd_En pulses.

Source files
------------

// File: rtl/frame_offset_reader_pkg.sv
// Shared types and constants for the frame offset reader: display defaults,
// pixel/coordinate/offset types and the QVGA frame-buffer address helper.
package frame_offset_reader_pkg;

  localparam int H_ACT_DEF = 640;
  localparam int V_ACT_DEF = 480;
  localparam int ADDR_W    = 17;
  localparam int COORD_W   = 10;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic signed [4:0]  offset_t;

  // A 320-wide buffer reduces to y*256 + y*64 + x, avoiding a multiplier.
  function automatic logic [ADDR_W-1:0] fb_addr(input coord_t x, input coord_t y, input int fb_w);
    logic [ADDR_W-1:0] yy;
    logic [ADDR_W-1:0] xx;
    yy = {7'd0, y};
    xx = {7'd0, x};
    if (fb_w == 320) begin
      fb_addr = (yy << 8) + (yy << 6) + xx;
    end else begin
      fb_addr = (yy * ADDR_W'(fb_w)) + xx;
    end
  endfunction

endpackage

// File: rtl/frame_offset_reader_delay_line.sv
// Parameterised WIDTH x DEPTH shift register with synchronous active-low reset;
// keeps timing, coordinates and the in-range flag aligned with read data.
module frame_offset_reader_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] taps [DEPTH];

  // Shift chain; reset empties every tap so nothing stale survives a flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else begin
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign q = taps[DEPTH-1];

endmodule

// File: rtl/frame_offset_reader.sv
// Shifts each VGA pixel by per-frame shake offsets and fetches it from the 2x-upscaled
// QVGA buffer. Define FRAME_READER_WRAP_EN to wrap out-of-range coordinates instead of bordering.
module frame_offset_reader
  import frame_offset_reader_pkg::*;
#(
  parameter int          H_ACT       = H_ACT_DEF,
  parameter int          V_ACT       = V_ACT_DEF,
  parameter int          SCALE_SHIFT = 1,
  parameter int          RD_LATENCY  = 1,
  parameter logic [11:0] BORDER_RGB  = 12'h000
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iH_Sync,
  input  logic              iV_Sync,
  input  logic              iDE,
  input  logic [9:0]        iX,
  input  logic [9:0]        iY,
  input  logic [4:0]        iX_Offset,
  input  logic [4:0]        iY_Offset,
  output logic [ADDR_W-1:0] oRd_Addr,
  output logic              oRd_En,
  input  logic [11:0]       iRd_Data,
  output logic              oH_Sync,
  output logic              oV_Sync,
  output logic              oDE,
  output logic [9:0]        oX,
  output logic [9:0]        oY,
  output logic [3:0]        oR,
  output logic [3:0]        oG,
  output logic [3:0]        oB,
  output logic              oFrame_Tick
);

  localparam int FB_W  = H_ACT >> SCALE_SHIFT;
  localparam int DEPTH = 2 + RD_LATENCY;
  localparam int DL_W  = 3 + 2 * COORD_W + 1;
  localparam logic signed [10:0] H_LIM = 11'(H_ACT);
  localparam logic signed [10:0] V_LIM = 11'(V_ACT);

  logic               vs_prev;
  offset_t            x_off;
  offset_t            y_off;
  logic signed [10:0] sx;
  logic signed [10:0] sy;
  coord_t             x_fb;
  coord_t             y_fb;
  logic               hit;
  coord_t             s1_x;
  coord_t             s1_y;
  logic               s1_hit;
  logic [DL_W-1:0]    dl_in;
  logic [DL_W-1:0]    dl_out;
  logic               de_d;
  logic               hit_d;
  rgb444_t            pix;

  // Offsets change only on a V_Sync rising edge so a whole frame shares one shift.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      vs_prev     <= 1'b0;
      x_off       <= '0;
      y_off       <= '0;
      oFrame_Tick <= 1'b0;
    end else begin
      vs_prev <= iV_Sync;
      if (iV_Sync && !vs_prev) begin
        x_off       <= offset_t'(iX_Offset);
        y_off       <= offset_t'(iY_Offset);
        oFrame_Tick <= 1'b1;
      end else begin
        oFrame_Tick <= 1'b0;
      end
    end
  end

  // Shifted coordinate, optional modulo wrap, and the fetch-valid flag.
  always_comb begin
    sx = $signed({1'b0, iX}) + $signed({{6{x_off[4]}}, x_off});
    sy = $signed({1'b0, iY}) + $signed({{6{y_off[4]}}, y_off});
`ifdef FRAME_READER_WRAP_EN
    if (sx[10]) begin
      x_fb = coord_t'(sx + H_LIM);
    end else if (sx >= H_LIM) begin
      x_fb = coord_t'(sx - H_LIM);
    end else begin
      x_fb = sx[9:0];
    end
    if (sy[10]) begin
      y_fb = coord_t'(sy + V_LIM);
    end else if (sy >= V_LIM) begin
      y_fb = coord_t'(sy - V_LIM);
    end else begin
      y_fb = sy[9:0];
    end
    hit = iDE;
`else
    x_fb = sx[9:0];
    y_fb = sy[9:0];
    hit  = iDE & ~sx[10] & (sx < H_LIM) & ~sy[10] & (sy < V_LIM);
`endif
  end

  // S1 registers the shifted coordinate; S2 forms the address, which holds while idle.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      s1_x     <= '0;
      s1_y     <= '0;
      s1_hit   <= 1'b0;
      oRd_Addr <= '0;
      oRd_En   <= 1'b0;
    end else begin
      s1_x   <= x_fb;
      s1_y   <= y_fb;
      s1_hit <= hit;
      oRd_En <= s1_hit;
      if (s1_hit) begin
        oRd_Addr <= fb_addr(s1_x >> SCALE_SHIFT, s1_y >> SCALE_SHIFT, FB_W);
      end
    end
  end

  assign dl_in = {iH_Sync, iV_Sync, iDE, iX, iY, hit};

  frame_offset_reader_delay_line #(
    .WIDTH (DL_W),
    .DEPTH (DEPTH)
  ) u_align (
    .clk   (iClk),
    .rst_n (iRst_n),
    .d     (dl_in),
    .q     (dl_out)
  );

  assign {oH_Sync, oV_Sync, de_d, oX, oY, hit_d} = dl_out;
  assign oDE = de_d;

  // Colour select against the aligned flags; read data arrives in step with them.
  always_comb begin
    if (de_d && hit_d) begin
      pix = rgb444_t'(iRd_Data);
    end else if (de_d) begin
      pix = rgb444_t'(BORDER_RGB);
    end else begin
      pix = '0;
    end
  end

  assign oR = pix.r;
  assign oG = pix.g;
  assign oB = pix.b;

endmodule

// File: tb/tb_frame_offset_reader.sv
// Directed bench for frame_offset_reader with a 1-cycle frame-buffer model returning addr[11:0].
module tb_frame_offset_reader;

`ifdef FRAME_READER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic        clk;
  logic        iRst_n;
  logic        iH_Sync;
  logic        iV_Sync;
  logic        iDE;
  logic [9:0]  iX;
  logic [9:0]  iY;
  logic [4:0]  iX_Offset;
  logic [4:0]  iY_Offset;
  logic [16:0] oRd_Addr;
  logic        oRd_En;
  logic [11:0] iRd_Data;
  logic        oH_Sync;
  logic        oV_Sync;
  logic        oDE;
  logic [9:0]  oX;
  logic [9:0]  oY;
  logic [3:0]  oR;
  logic [3:0]  oG;
  logic [3:0]  oB;
  logic        oFrame_Tick;

  logic [11:0] ram_q;
  int          n_cmp;
  int          n_err;
  int          last_addr;

  frame_offset_reader dut (
    .iClk        (clk),
    .iRst_n      (iRst_n),
    .iH_Sync     (iH_Sync),
    .iV_Sync     (iV_Sync),
    .iDE         (iDE),
    .iX          (iX),
    .iY          (iY),
    .iX_Offset   (iX_Offset),
    .iY_Offset   (iY_Offset),
    .oRd_Addr    (oRd_Addr),
    .oRd_En      (oRd_En),
    .iRd_Data    (iRd_Data),
    .oH_Sync     (oH_Sync),
    .oV_Sync     (oV_Sync),
    .oDE         (oDE),
    .oX          (oX),
    .oY          (oY),
    .oR          (oR),
    .oG          (oG),
    .oB          (oB),
    .oFrame_Tick (oFrame_Tick)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(posedge clk) begin
    if (oRd_En) ram_q <= oRd_Addr[11:0];
  end
  assign iRd_Data = ram_q;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated pixel: address/strobe two edges later, colour and timing three edges later.
  task automatic pix(input string tag, input int x, input int y, input bit de,
                     input bit en_exp, input int addr_exp, input int rgb_exp);
    iX = 10'(x); iY = 10'(y); iDE = de;
    tick();
    iX = 10'd0; iY = 10'd0; iDE = 1'b0;
    tick();
    if (en_exp) last_addr = addr_exp;
    chk({tag, ".en"}, 32'(oRd_En), 32'(en_exp));
    chk({tag, ".addr"}, 32'(oRd_Addr), 32'(last_addr));
    chk({tag, ".early_de"}, 32'(oDE), 32'd0);
    tick();
    chk({tag, ".de"}, 32'(oDE), 32'(de));
    chk({tag, ".x"}, 32'(oX), 32'(x));
    chk({tag, ".y"}, 32'(oY), 32'(y));
    chk({tag, ".rgb"}, 32'({oR, oG, oB}), 32'(rgb_exp));
  endtask

  task automatic new_frame(input string tag, input logic [4:0] xo, input logic [4:0] yo);
    iDE = 1'b0; iV_Sync = 1'b0;
    tick();
    iV_Sync = 1'b1; iX_Offset = xo; iY_Offset = yo;
    tick();
    chk({tag, ".tick"}, 32'(oFrame_Tick), 32'd1);
    iX_Offset = 5'd7; iY_Offset = 5'd9;
    tick();
    chk({tag, ".tick_end"}, 32'(oFrame_Tick), 32'd0);
    iV_Sync = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp = 0; n_err = 0; last_addr = 0;

    // Reset with random activity on every input
    iRst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iH_Sync = 1'($urandom); iV_Sync = 1'($urandom); iDE = 1'b1;
      iX = 10'($urandom_range(0, 639)); iY = 10'($urandom_range(0, 479));
      iX_Offset = 5'($urandom); iY_Offset = 5'($urandom);
      tick();
    end
    chk("rst.addr", 32'(oRd_Addr), 32'd0);
    chk("rst.en", 32'(oRd_En), 32'd0);
    chk("rst.sync", 32'({oH_Sync, oV_Sync, oDE}), 32'd0);
    chk("rst.xy", 32'({oX, oY}), 32'd0);
    chk("rst.rgb", 32'({oR, oG, oB}), 32'd0);
    chk("rst.tick", 32'(oFrame_Tick), 32'd0);

    iRst_n = 1'b1; iH_Sync = 1'b0; iV_Sync = 1'b0; iDE = 1'b0;
    iX = 10'd0; iY = 10'd0; iX_Offset = 5'd0; iY_Offset = 5'd0;
    tick();
    chk("rel.en", 32'(oRd_En), 32'd0);

    // Zero offset
    pix("z00", 0, 0, 1'b1, 1'b1, 0, 12'h000);
    pix("z10", 1, 0, 1'b1, 1'b1, 0, 12'h000);
    pix("z20", 2, 0, 1'b1, 1'b1, 1, 12'h001);
    pix("zmax", 639, 479, 1'b1, 1'b1, 76799, 12'hBFF);
    pix("zmid", 100, 50, 1'b1, 1'b1, 8050, 12'hF72);
    pix("zde0", 8, 8, 1'b0, 1'b0, 0, 12'h000);

    // Back-to-back pixels, one read per cycle
    iDE = 1'b1; iY = 10'd0; iX = 10'd2;
    tick();
    iX = 10'd4;
    tick();
    chk("st.a1", 32'(oRd_Addr), 32'd1);
    iX = 10'd6;
    tick();
    chk("st.a2", 32'(oRd_Addr), 32'd2);
    chk("st.o1", 32'({oDE, oX, oR, oG, oB}), 32'({1'b1, 10'd2, 12'h001}));
    iDE = 1'b0; iX = 10'd0;
    tick();
    chk("st.a3", 32'(oRd_Addr), 32'd3);
    chk("st.o2", 32'({oDE, oX, oR, oG, oB}), 32'({1'b1, 10'd4, 12'h002}));
    tick();
    chk("st.o3", 32'({oDE, oX, oR, oG, oB}), 32'({1'b1, 10'd6, 12'h003}));
    tick();
    chk("st.end", 32'(oDE), 32'd0);
    last_addr = 3;

    // H_Sync takes the same three-edge path
    iH_Sync = 1'b1;
    tick();
    iH_Sync = 1'b0;
    tick();
    chk("hs.early", 32'(oH_Sync), 32'd0);
    tick();
    chk("hs.on", 32'(oH_Sync), 32'd1);
    tick();
    chk("hs.off", 32'(oH_Sync), 32'd0);

    // Offsets latch only on a V_Sync rising edge
    new_frame("f1", 5'd3, 5'd0);
    pix("o3", 10, 0, 1'b1, 1'b1, 6, 12'h006);
    iX_Offset = 5'b11100;
    pix("o3hold", 10, 0, 1'b1, 1'b1, 6, 12'h006);
    new_frame("f2", 5'b11100, 5'd0);
    pix("om4", 10, 0, 1'b1, 1'b1, 3, 12'h003);

    // X -16, Y +15
    new_frame("f3", 5'b10000, 5'b01111);
    pix("b_x5", 5, 100, 1'b1, WRAP, WRAP ? 18554 : 0, WRAP ? 12'h87A : 12'h000);
    pix("b_x0", 0, 0, 1'b1, WRAP, WRAP ? 2552 : 0, WRAP ? 12'h9F8 : 12'h000);
    pix("b_x15", 15, 0, 1'b1, WRAP, WRAP ? 2559 : 0, WRAP ? 12'h9FF : 12'h000);
    pix("b_x16", 16, 0, 1'b1, 1'b1, 2240, 12'h8C0);
    pix("b_y465", 100, 465, 1'b1, WRAP, WRAP ? 42 : 0, WRAP ? 12'h02A : 12'h000);
    pix("b_y464", 100, 464, 1'b1, 1'b1, 76522, 12'hAEA);
    pix("b_de0", 5, 100, 1'b0, 1'b0, 0, 12'h000);

    // X +15
    new_frame("f4", 5'b01111, 5'd0);
    pix("p630", 630, 0, 1'b1, WRAP, WRAP ? 2 : 0, WRAP ? 12'h002 : 12'h000);
    pix("p624", 624, 0, 1'b1, 1'b1, 319, 12'h13F);

    // Reset in the middle of line 200
    new_frame("f5", 5'd0, 5'd0);
    iDE = 1'b1; iY = 10'd200;
    for (int i = 0; i < 3; i++) begin
      iX = 10'(i);
      tick();
    end
    iRst_n = 1'b0;
    tick();
    chk("mr.en", 32'(oRd_En), 32'd0);
    chk("mr.addr", 32'(oRd_Addr), 32'd0);
    chk("mr.de_y", 32'({oDE, oY}), 32'd0);
    chk("mr.rgb", 32'({oR, oG, oB}), 32'd0);
    tick();
    iRst_n = 1'b1; iDE = 1'b0; iX = 10'd0; iY = 10'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mr.flush_en", 32'(oRd_En), 32'd0);
      chk("mr.flush_de", 32'(oDE), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
